// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Memory-side responder for the cpu's command bus. Each accepted command is
//   routed either to the external 256x16 synchronous RAM (addr[8]=0) or to
//   memory-mapped I/O (addr[8]=1): a write-only LED register and a read-only
//   switch port. Every command, legal or not, completes with a one-cycle
//   mem_ready strobe, except the illegal command code, which only flags an error.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   mem_cmd     in   [1:0] 00 none, 01 read, 10 write, 11 illegal
//   mem_addr    in   [8:0] word address, bit 8 selects I/O
//   write_data  in   [15:0] store data
//   read_data   out  [15:0] registered load data, valid while mem_ready=1
//   mem_ready   out  one-cycle completion strobe
//   bus_err     out  sticky error flag (illegal command or unmapped I/O)
//   ram_addr    out  [7:0] RAM address
//   ram_write   out  RAM write enable
//   ram_din     out  [15:0] RAM write data
//   ram_dout    in   [15:0] RAM read data, one cycle after the address
//   sw_in       in   [7:0] switch inputs
//   led_out     out  [7:0] LED register
//
// State table
//   IDLE | waiting for a command; the only state that samples mem_cmd
//   RD   | read accepted; counting wait states, RAM data arriving
//   RESP | read response cycle, mem_ready=1
//   WACK | write acknowledge cycle, mem_ready=1

module mem_bus_responder #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [8:0]  LED_ADDR    = 9'h100,
  parameter logic [8:0]  SW_ADDR     = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic        bus_err,
  output logic [7:0]  ram_addr,
  output logic        ram_write,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2,
    WACK = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [8:0]  addr_q;
  logic [3:0]  cnt;

  logic        accept;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        rd_load;
  logic        led_load;
  logic        err_set;
  logic [15:0] rd_value;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    rd_load   = 1'b0;
    led_load  = 1'b0;
    err_set   = 1'b0;
    ram_write = 1'b0;
    mem_ready = 1'b0;

    case (state)
      IDLE: begin
        case (mem_cmd)
          CMD_READ: begin
            accept    = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = RD;
          end
          CMD_WRITE: begin
            accept    = 1'b1;
            state_nxt = WACK;
            // The RAM captures the store on the accepting edge itself;
            // gating with reset keeps a held command from writing during reset.
            ram_write = ~mem_addr[8] & ~reset;
            if (mem_addr == LED_ADDR) begin
              led_load = 1'b1;
            end else if (mem_addr[8]) begin
              err_set = 1'b1;
            end
          end
          CMD_ILL: begin
            err_set = 1'b1;
          end
          default: begin
          end
        endcase
      end
      RD: begin
        if (cnt < WS) begin
          cnt_inc = 1'b1;
        end else begin
          rd_load   = 1'b1;
          state_nxt = RESP;
          if (addr_q[8] && (addr_q != SW_ADDR)) begin
            err_set = 1'b1;
          end
        end
      end
      RESP: begin
        mem_ready = 1'b1;
        state_nxt = IDLE;
      end
      WACK: begin
        mem_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Load-data source selected from the latched address at the RD exit edge.
  always_comb begin
    rd_value = 16'h0000;
    if (!addr_q[8]) begin
      rd_value = ram_dout;
    end else if (addr_q == SW_ADDR) begin
      rd_value = {8'h00, sw_in};
    end
  end

  // In IDLE the RAM sees the live bus address so a read's data is ready one
  // cycle after acceptance; afterwards it is held from the latched address.
  assign ram_addr = (state == IDLE) ? mem_addr[7:0] : addr_q[7:0];
  assign ram_din  = write_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= 9'h000;
    end else if (accept) begin
      addr_q <= mem_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'h0;
    end else if (cnt_clr) begin
      cnt <= 4'h0;
    end else if (cnt_inc) begin
      cnt <= cnt + 4'h1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= 16'h0000;
    end else if (rd_load) begin
      read_data <= rd_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= 8'h00;
    end else if (led_load) begin
      led_out <= write_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (err_set) begin
      bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MILL   = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw_in;

  logic [1:0]  mem_cmd    [2];
  logic [8:0]  mem_addr   [2];
  logic [15:0] write_data [2];
  logic [15:0] read_data  [2];
  logic        mem_ready  [2];
  logic        bus_err    [2];
  logic [7:0]  ram_addr   [2];
  logic        ram_write  [2];
  logic [15:0] ram_din    [2];
  logic [7:0]  led_out    [2];

  always #5 clk = ~clk;

  // Instance 0 has no wait states, instance 1 has three; each owns a RAM.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] ram [256];
    logic [15:0] ram_dout;

    initial begin
      for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
      ram_dout = 16'h0000;
    end

    always @(posedge clk) begin
      if (ram_write[g]) ram[ram_addr[g]] <= ram_din[g];
      ram_dout <= ram[ram_addr[g]];
    end

    mem_bus_responder #(.WAIT_STATES(g * 3)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .mem_cmd    (mem_cmd[g]),
      .mem_addr   (mem_addr[g]),
      .write_data (write_data[g]),
      .read_data  (read_data[g]),
      .mem_ready  (mem_ready[g]),
      .bus_err    (bus_err[g]),
      .ram_addr   (ram_addr[g]),
      .ram_write  (ram_write[g]),
      .ram_din    (ram_din[g]),
      .ram_dout   (ram_dout),
      .sw_in      (sw_in),
      .led_out    (led_out[g])
    );
  end

  // Reference model: what the cpu should observe, per instance.
  int          ws [2] = '{0, 3};
  logic [15:0] m_mem [2][256];
  logic [15:0] m_rd  [2];
  logic [7:0]  m_led [2];
  logic        m_err [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rd[d]  = 16'h0000;
      m_led[d] = 8'h00;
      m_err[d] = 1'b0;
    end
  endtask

  // Issue one command on instance d from a negedge; returns at a negedge
  // after the cpu has dropped the command.
  task automatic xact(input int d, input logic [1:0] cmd, input logic [8:0] addr,
                      input logic [15:0] data);
    int   edges;
    int   exp_lat;
    logic seen;

    if (cmd == MWRITE) begin
      exp_lat = 1;
      if (!addr[8]) m_mem[d][addr[7:0]] = data;
      else if (addr == 9'h100) m_led[d] = data[7:0];
      else m_err[d] = 1'b1;
    end else begin
      exp_lat = 2 + ws[d];
      if (!addr[8]) m_rd[d] = m_mem[d][addr[7:0]];
      else if (addr == 9'h140) m_rd[d] = {8'h00, sw_in};
      else begin
        m_rd[d]  = 16'h0000;
        m_err[d] = 1'b1;
      end
    end

    mem_cmd[d]    = cmd;
    mem_addr[d]   = addr;
    write_data[d] = data;
    #1;
    chk("ram_write_issue", {15'h0, ram_write[d]}, {15'h0, (cmd == MWRITE) && !addr[8]});
    chk("ram_addr_issue", {8'h00, ram_addr[d]}, {8'h00, addr[7:0]});
    if (cmd == MWRITE) chk("ram_din", ram_din[d], data);

    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      chk("ram_write_busy", {15'h0, ram_write[d]}, 16'h0000);
      if (mem_ready[d] === 1'b1) seen = 1'b1;
    end
    chk("ready_seen", {15'h0, seen}, 16'h0001);
    chk("latency", edges[15:0], exp_lat[15:0]);
    chk("read_data", read_data[d], m_rd[d]);
    chk("bus_err", {15'h0, bus_err[d]}, {15'h0, m_err[d]});
    chk("led_out", {8'h00, led_out[d]}, {8'h00, m_led[d]});

    @(posedge clk);
    #1;
    mem_cmd[d] = MNONE;
    @(negedge clk);
    chk("ready_one_cycle", {15'h0, mem_ready[d]}, 16'h0000);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) m_mem[d][i] = 16'h0000;
      mem_cmd[d]    = MWRITE;
      mem_addr[d]   = 9'h003;
      write_data[d] = 16'hDEAD;
    end
    model_reset();
    sw_in = 8'h00;
    reset = 1'b1;

    // Reset state, with a RAM write held on the bus.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_read_data", read_data[d], 16'h0000);
      chk("rst_mem_ready", {15'h0, mem_ready[d]}, 16'h0000);
      chk("rst_bus_err", {15'h0, bus_err[d]}, 16'h0000);
      chk("rst_led_out", {8'h00, led_out[d]}, 16'h0000);
      chk("rst_ram_write", {15'h0, ram_write[d]}, 16'h0000);
      mem_cmd[d] = MNONE;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Write then read RAM, no wait states.
    xact(0, MWRITE, 9'h005, 16'hABCD);
    xact(0, MREAD,  9'h005, 16'h0000);
    chk("t1_data", read_data[0], 16'hABCD);

    // Switch port read.
    sw_in = 8'h5A;
    xact(0, MREAD, 9'h140, 16'h0000);
    chk("t2_data", read_data[0], 16'h005A);
    chk("t2_err", {15'h0, bus_err[0]}, 16'h0000);

    // LED write; read_data must keep its last load value.
    xact(0, MWRITE, 9'h100, 16'h1234);
    chk("t3_led", {8'h00, led_out[0]}, 16'h0034);
    chk("t3_rd_hold", read_data[0], 16'h005A);

    // Three wait states.
    xact(1, MWRITE, 9'h0FF, 16'h7777);
    xact(1, MREAD,  9'h0FF, 16'h0000);
    chk("t4_data", read_data[1], 16'h7777);

    // Illegal command: sticky error, no strobe, stays in IDLE.
    mem_cmd[0]  = MILL;
    mem_addr[0] = 9'h055;
    m_err[0]    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ill_ready", {15'h0, mem_ready[0]}, 16'h0000);
      chk("ill_idle_addr", {8'h00, ram_addr[0]}, 16'h0055);
    end
    mem_cmd[0] = MNONE;
    @(negedge clk);
    chk("ill_err_sticky", {15'h0, bus_err[0]}, 16'h0001);
    chk("ill_other_err", {15'h0, bus_err[1]}, 16'h0000);
    xact(1, MREAD, 9'h1F0, 16'h0000);
    chk("t5_data", read_data[1], 16'h0000);

    // Reset in the middle of a waited read.
    mem_cmd[1]  = MREAD;
    mem_addr[1] = 9'h0FF;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset       = 1'b1;
    mem_addr[1] = 9'h0AA;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mid_rst_ready", {15'h0, mem_ready[d]}, 16'h0000);
      chk("mid_rst_rd", read_data[d], 16'h0000);
      chk("mid_rst_led", {8'h00, led_out[d]}, 16'h0000);
      chk("mid_rst_err", {15'h0, bus_err[d]}, 16'h0000);
    end
    chk("mid_rst_idle", {8'h00, ram_addr[1]}, 16'h00AA);
    mem_cmd[1] = MNONE;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    xact(1, MREAD, 9'h0FF, 16'h0000);
    chk("t6_data", read_data[1], 16'h7777);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      int          d;
      int          r;
      logic [1:0]  cmd;
      logic [8:0]  addr;
      logic [15:0] data;
      d     = int'($urandom_range(0, 1));
      r     = int'($urandom_range(0, 9));
      cmd   = ($urandom_range(0, 1) == 0) ? MREAD : MWRITE;
      data  = 16'($urandom);
      sw_in = 8'($urandom);
      case (r)
        0:       addr = 9'h100;
        1:       addr = 9'h140;
        2:       addr = {1'b1, 8'($urandom)};
        default: addr = {1'b0, 4'($urandom), 4'($urandom_range(0, 3))};
      endcase
      xact(d, cmd, addr, data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
